// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store at a time, answered exactly
// LATENCY cycles after acceptance, with alignment/range faults and reset-cleared storage.
module data_mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  state_t                  state;
  logic [3:0]              cnt;
  mem_req_t                req_q;
  logic [DEPTH-1:0][31:0]  mem;

  logic                    src_we;
  logic [31:0]             src_addr;
  logic [AW-1:0]           src_idx;
  logic                    src_fault;
  logic [31:0]             src_rdata;
  logic [AW-1:0]           wr_idx;

  // The response is computed on the edge that enters RESP. With LATENCY=1 that
  // edge is the acceptance edge itself, so the live inputs stand in for req_q.
  assign src_we    = (state == IDLE) ? we_i   : req_q.we;
  assign src_addr  = (state == IDLE) ? addr_i : req_q.addr;
  assign src_idx   = src_addr[AW+1:2];
  assign src_fault = (src_addr[1:0] != 2'b00) || (src_addr[31:AW+2] != '0);
  assign src_rdata = (src_we || src_fault) ? 32'h0 : mem[src_idx];
  assign wr_idx    = req_q.addr[AW+1:2];

  assign busy_o = rst_i && ((state != IDLE) || req_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
      mem     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            req_q <= '{we: we_i, addr: addr_i, wdata: wdata_i};
            cnt   <= CNT_INIT;
            if (LATENCY > 1) begin
              state <= WAIT;
            end else begin
              state   <= RESP;
              ack_o   <= 1'b1;
              err_o   <= src_fault;
              rdata_o <= src_rdata;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state   <= RESP;
            ack_o   <= 1'b1;
            err_o   <= src_fault;
            rdata_o <= src_rdata;
          end
        end
        RESP: begin
          // err_o holds the fault flag of the request being answered
          if (req_q.we && !err_o) mem[wr_idx] <= req_q.wdata;
          state   <= IDLE;
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          rdata_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=4 and LATENCY=1 instances driven
// in turn, responses checked against a word-array model of the memory.
module tb_data_mem_responder;
  localparam int DEPTH = 32;
  localparam int NU    = 2;

  typedef struct {
    int          acc;
    bit          we;
    bit          fault;
    int          idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req   [NU];
  logic        we    [NU];
  logic [31:0] addr  [NU];
  logic [31:0] wdata [NU];
  logic        ack   [NU];
  logic        busy  [NU];
  logic        err   [NU];
  logic [31:0] rdata [NU];

  exp_t        sb    [NU][$];
  logic [31:0] model [NU][DEPTH];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  data_mem_responder #(.LATENCY(4), .DEPTH(DEPTH)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .busy_o(busy[0]), .err_o(err[0])
  );

  data_mem_responder #(.LATENCY(1), .DEPTH(DEPTH)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .busy_o(busy[1]), .err_o(err[1])
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int lat_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  task automatic chk(input int u, input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL lat%0d %s: got %0h want %0h (edge %0d)", lat_of(u), name, act, want, cyc);
    end
  endtask

  task automatic clear_model();
    for (int u = 0; u < NU; u++) begin
      sb[u].delete();
      for (int i = 0; i < DEPTH; i++) model[u][i] = 32'h0;
    end
  endtask

  // Monitor: sampled mid-low-phase, well clear of the rising edge.
  task automatic check_unit(input int u);
    bit   outst;
    bit   exp_ack;
    exp_t e;
    if (!rst_i) begin
      chk(u, "reset_outputs", {29'd0, ack[u], busy[u], err[u], rdata[u]}, 64'd0);
      return;
    end
    outst   = (sb[u].size() > 0) && (sb[u][0].acc <= cyc);
    exp_ack = outst && (cyc == sb[u][0].acc + lat_of(u) - 1);
    chk(u, "busy", busy[u], outst ? 1'b1 : req[u]);
    chk(u, "ack", ack[u], exp_ack);
    if (exp_ack) begin
      e = sb[u].pop_front();
      if (ack[u]) begin
        chk(u, "rdata", rdata[u], e.rdata);
        chk(u, "err", err[u], e.fault);
      end
      if (e.we && !e.fault) model[u][e.idx] = e.wdata;
    end else if (!ack[u]) begin
      chk(u, "idle_rdata_err", {err[u], rdata[u]}, 64'd0);
    end
  endtask

  always begin
    @(negedge clk_i);
    #3;
    for (int u = 0; u < NU; u++) check_unit(u);
  end

  // Drive a request for the next rising edge; the unit must be idle here.
  task automatic start(input int u, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.acc   = cyc + 1;
    e.we    = w;
    e.fault = (a % 4 != 0) || (a / 4 >= 32'(DEPTH));
    e.idx   = e.fault ? 0 : int'(a / 4);
    e.wdata = d;
    e.rdata = (!w && !e.fault) ? model[u][e.idx] : 32'h0;
    sb[u].push_back(e);
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
  endtask

  // While the request is outstanding, throw junk (or a held-high req) at the
  // inputs; none of it may be accepted or disturb the latched fields.
  task automatic finish(input int u, input bit hold);
    int guard = 0;
    @(negedge clk_i);
    while (sb[u].size() != 0 && guard < 20) begin
      req[u]   = hold ? 1'b1 : 1'($urandom_range(0, 1));
      we[u]    = 1'($urandom_range(0, 1));
      addr[u]  = $urandom;
      wdata[u] = $urandom;
      guard++;
      @(negedge clk_i);
    end
    tests++;
    if (sb[u].size() != 0) begin
      fails++;
      $display("FAIL lat%0d ack_timeout: got %0d pending want 0 (edge %0d)", lat_of(u), sb[u].size(), cyc);
      sb[u].delete();
    end
  endtask

  task automatic issue(input int u, input bit w, input logic [31:0] a, input logic [31:0] d, input bit hold);
    start(u, w, a, d);
    finish(u, hold);
  endtask

  task automatic idle(input int u, input int n);
    req[u] = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
      2:       return 32'($urandom_range(DEPTH, 4 * DEPTH) * 4);
      default: return 32'($urandom_range(0, DEPTH - 1) * 4);
    endcase
  endfunction

  task automatic directed(input int u);
    issue(u, 1'b0, 32'h8, 32'h0, 1'b0);
    idle(u, 2);
    issue(u, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(u, 1'b0, 32'h10, 32'h0, 1'b0);
    idle(u, 1);
    issue(u, 1'b1, 32'h0, 32'h11223344, 1'b0);
    issue(u, 1'b0, 32'h6, 32'h0, 1'b0);
    issue(u, 1'b1, 32'h80, 32'h0BAD0BAD, 1'b0);
    issue(u, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(u, 2);
    for (int i = 0; i < 3; i++) issue(u, 1'b0, 32'(4 * (i + 3)), 32'h0, 1'b1);
    idle(u, 6);
  endtask

  task automatic random_run(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle(u, $urandom_range(1, 3));
      issue(u, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)));
    end
    idle(u, 4);
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      req[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
    end
    clear_model();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;

    directed(0);
    random_run(0, 40);

    // Reset dropped in the middle of a store's WAIT phase.
    issue(0, 1'b1, 32'h4, 32'h12345678, 1'b0);
    start(0, 1'b1, 32'h4, 32'hCAFEF00D);
    @(negedge clk_i);
    req[0] = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_model();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    idle(0, 2);
    issue(0, 1'b0, 32'h4, 32'h0, 1'b0);
    idle(0, 2);

    directed(1);
    random_run(1, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
    $fatal(1);
  end
endmodule
